// File: rtl/regs_if.sv
// Control/data bundle between the multiplier controller, adder and the regs accumulator.
// shift_cnt/done exist only when REGS_SHIFT_COUNT_EN is defined.
interface regs_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic               RESET;
  logic               ADD;
  logic               SHIFT;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH:0]   register;
`ifdef REGS_SHIFT_COUNT_EN
  logic [CW-1:0]      shift_cnt;
  logic               done;

  modport master (
    output RESET, ADD, SHIFT, sum, carry, multiplier,
    input  register, shift_cnt, done
  );

  modport slave (
    input  RESET, ADD, SHIFT, sum, carry, multiplier,
    output register, shift_cnt, done
  );
`else
  modport master (
    output RESET, ADD, SHIFT, sum, carry, multiplier,
    input  register
  );

  modport slave (
    input  RESET, ADD, SHIFT, sum, carry, multiplier,
    output register
  );
`endif
endinterface

// File: rtl/regs.sv
// Accumulator/multiplier register {carry, partial sum, multiplier} for a shift-and-add multiplier.
// Latency: every clocked update is visible one edge later; output is purely registered.
// Backpressure: none, commands are accepted every cycle. Optional shift counter: REGS_SHIFT_COUNT_EN.
module regs #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  n_reset,
  regs_if.slave bus
);

  logic [2*WIDTH:0] reg_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      reg_q <= '0;
    end else if (bus.RESET) begin
      reg_q <= {{(WIDTH+1){1'b0}}, bus.multiplier};
    end else begin
      unique case ({bus.ADD, bus.SHIFT})
        2'b10:   reg_q <= {bus.carry, bus.sum, reg_q[WIDTH-1:0]};
        2'b01:   reg_q <= {1'b0, reg_q[2*WIDTH:1]};
        // Shift-add: the ADD result already moved one place right.
        2'b11:   reg_q <= {1'b0, bus.carry, bus.sum, reg_q[WIDTH-1:1]};
        default: reg_q <= reg_q;
      endcase
    end
  end

  assign bus.register = reg_q;

`ifdef REGS_SHIFT_COUNT_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else if (bus.RESET) begin
      cnt_q <= '0;
    end else if (bus.SHIFT && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.shift_cnt = cnt_q;
  assign bus.done      = (cnt_q == CNT_MAX);
`endif

endmodule

// File: tb/tb_regs.sv
// Directed-vector bench for regs (WIDTH=8); shift counter vectors run when REGS_SHIFT_COUNT_EN is defined.
module tb_regs;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic n_reset;
  int   errors = 0;
  int   checks = 0;

  regs_if #(.WIDTH(WIDTH)) bus ();

  regs #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic add, input logic shf,
                       input logic [7:0] s, input logic c, input logic [7:0] m);
    bus.RESET      = rst;
    bus.ADD        = add;
    bus.SHIFT      = shf;
    bus.sum        = s;
    bus.carry      = c;
    bus.multiplier = m;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF);
    #1;
    check("reset_no_edge", 32'(bus.register), 32'h0);
    tick();
    check("reset_dominates_edge", 32'(bus.register), 32'h0);
`ifdef REGS_SHIFT_COUNT_EN
    check("reset_cnt", 32'(bus.shift_cnt), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
`endif
    #2 n_reset = 1'b1;

    // Spec walkthrough: 73 * partial-product steps.
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd73);
    tick();
    check("load_mult", 32'(bus.register), 32'(17'b0_00000000_01001001));

    drive(1'b0, 1'b1, 1'b0, 8'd152, 1'b1, 8'd0);
    tick();
    check("add", 32'(bus.register), 32'(17'b1_10011000_01001001));

    drive(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0);
    tick();
    check("shift", 32'(bus.register), 32'(17'b0_11001100_00100100));

    drive(1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 8'h55);
    tick();
    check("hold", 32'(bus.register), 32'(17'b0_11001100_00100100));

    drive(1'b0, 1'b1, 1'b1, 8'd152, 1'b1, 8'd0);
    tick();
    check("shift_add", 32'(bus.register), 32'(17'b0_11001100_00010010));

    // RESET wins over simultaneous ADD.
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 8'd73);
    tick();
    check("reload_mid_op", 32'(bus.register), 32'(17'b0_00000000_01001001));

    // Second pattern: multiplier 0xA5, carry=0 add, plain shift, carry-only shift-add.
    drive(1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'hA5);
    tick();
    check("reload_all_ctrl", 32'(bus.register), 32'({1'b0, 8'h00, 8'hA5}));

    drive(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h00);
    tick();
    check("add_no_carry", 32'(bus.register), 32'({1'b0, 8'hFF, 8'hA5}));

    // Inputs changing between edges must not disturb the output.
    drive(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
    #2;
    check("no_change_between_edges", 32'(bus.register), 32'({1'b0, 8'hFF, 8'hA5}));

    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    tick();
    check("shift_lsb_discard", 32'(bus.register), 32'({1'b0, 8'h7F, 8'hD2}));

    drive(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
    tick();
    check("shift_add_carry", 32'(bus.register), 32'({1'b0, 8'h80, 8'h69}));

    // Asynchronous reset asserted mid-cycle.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    #2 n_reset = 1'b0;
    #1;
    check("async_reset_mid_cycle", 32'(bus.register), 32'h0);
    #1 n_reset = 1'b1;

`ifdef REGS_SHIFT_COUNT_EN
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF);
    tick();
    check("cnt_after_reset", 32'(bus.shift_cnt), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      // Alternate plain shifts and shift-adds; both count.
      drive(1'b0, i[0], 1'b1, 8'h01, 1'b0, 8'h00);
      tick();
      if (i == 7) check("done_low_at_7", 32'(bus.done), 32'd0);
      if (i == 8) check("done_at_8", 32'(bus.done), 32'd1);
      if (i == 8) check("cnt_at_8", 32'(bus.shift_cnt), 32'd8);
    end
    check("cnt_saturates", 32'(bus.shift_cnt), 32'd8);
    drive(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00);
    tick();
    check("cnt_add_only_holds", 32'(bus.shift_cnt), 32'd8);
    drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    tick();
    check("cnt_cleared_by_reset", 32'(bus.shift_cnt), 32'd0);
    check("done_cleared_by_reset", 32'(bus.done), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
